result_drain: RTL and testbench
===============================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter N, default 4, meaning matrix dimension (N x N elements).
REQ-002 SHALL have parameter DW, default 8, meaning element width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port s_flat  input  N*N*DW  result matrix from the multiplier array; element (r,c) at bits [(r*N+c)*DW +: DW].
REQ-006 SHALL have port finished  input  1  multiplier-done level; a 0->1 transition marks a new valid result.
REQ-007 SHALL have port out_data  output  DW  current streamed element.
REQ-008 SHALL have port out_row  output  $clog2(N)  row index of out_data.
REQ-009 SHALL have port out_col  output  $clog2(N)  column index of out_data.
REQ-010 SHALL have port out_valid  output  1  out_data/out_row/out_col/out_last are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the beat when high with out_valid.
REQ-012 SHALL have port out_last  output  1  high on element (N-1,N-1).
REQ-013 SHALL have port busy  output  1  high while a captured matrix is not fully drained.
REQ-014 SHALL have port overrun  output  1  sticky flag: a result arrived while draining and was dropped.
REQ-015 SHALL have port clr_ovr  input  1  synchronous clear of overrun.

Function
REQ-016 SHALL register finished into fin_q each cycle; rise = finished & ~fin_q.
REQ-017 SHALL implement FSM states IDLE and DRAIN; IDLE->DRAIN on rise, DRAIN->IDLE on acceptance of the last beat with no coincident rise.
REQ-018 SHALL, on rise in IDLE, copy all N*N elements of s_flat into an internal buffer in that same edge; later s_flat changes SHALL NOT affect streamed data.
REQ-019 SHALL present element (0,0) with out_valid=1 in the cycle after the capture edge (latency 1).
REQ-020 SHALL stream elements row-major, index 0..N*N-1; out_row = index/N, out_col = index%N.
REQ-021 SHALL advance index by one on each cycle with out_valid & out_ready; no bubbles between accepted beats.
REQ-022 SHALL hold out_data, out_row, out_col, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL assert out_last only when index = N*N-1 and out_valid=1.
REQ-024 SHALL deassert out_valid and busy in the cycle after the last beat is accepted; index wraps to 0.
REQ-025 SHALL, on rise while in DRAIN and not on the last accepted beat, drop the new result, keep streaming the old buffer unchanged, and set overrun.
REQ-026 SHALL, on rise coinciding with acceptance of the last beat, capture the new matrix, stay in DRAIN, and present its (0,0) next cycle with out_valid=1; overrun unchanged.
REQ-027 SHALL clear overrun when clr_ovr=1; a simultaneous set (REQ-025) SHALL take priority over clr_ovr.
REQ-028 SHALL make busy equal to (state == DRAIN).
REQ-029 SHALL use out_data as a registered output (driven from buffer via registered index, no combinational path from s_flat).

Reset
REQ-030 SHALL, while rst=1, force state=IDLE, index=0, out_valid=0, out_last=0, busy=0, overrun=0, out_data=0, out_row=0, out_col=0, buffer=0.
REQ-031 SHALL reset fin_q to 1 so a finished level already high at reset release causes no capture; a genuine 0->1 is required.
REQ-032 SHALL abandon any in-progress drain on rst assertion mid-stream; no further beats until the next rise after release.

Verification
REQ-033 SHALL cover basic drain: s_flat element (r,c)=16*r+c, finished 0->1, out_ready=1 -> 16 consecutive beats 0x00..0x33 row-major starting 1 cycle later, out_last on 0x33 only, busy low the cycle after.
REQ-034 SHALL cover backpressure: out_ready toggled 1,0,0,1 pattern -> each element appears exactly once, held stable during stalls, order preserved.
REQ-035 SHALL cover overrun: second finished rise at beat 5 with different s_flat -> stream continues with original data, overrun=1 after; clr_ovr pulse -> overrun=0.
REQ-036 SHALL cover back-to-back: rise coincident with accepted beat 15 -> next cycle out_valid=1 with new (0,0), no idle gap, overrun=0.
REQ-037 SHALL cover reset: rst asserted mid-drain at beat 7 with finished held 1 -> all outputs 0 immediately; after release no beats until finished goes 0 then 1.
REQ-038 SHALL cover input isolation: s_flat changed every cycle after capture -> streamed values equal the snapshot at the capture edge.

Source files
------------

// File: rtl/result_drain.sv
// Snapshots an N x N result matrix on each rising edge of finished.
// It then streams the snapshot row-major over a valid/ready handshake with row/col tags.
module result_drain #(
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N*N*DW-1:0]      s_flat,
   input  logic                   finished,
   output logic [DW-1:0]          out_data,
   output logic [$clog2(N)-1:0]   out_row,
   output logic [$clog2(N)-1:0]   out_col,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   busy,
   output logic                   overrun,
   input  logic                   clr_ovr
);

   localparam int unsigned RW = $clog2(N);
   localparam int unsigned IW = $clog2(N*N);
   localparam logic [RW-1:0] LastRc  = RW'(N - 1);
   localparam logic [IW-1:0] LastIdx = IW'(N*N - 1);

   typedef enum logic {StIdle, StDrain} state_e;

   state_e        state_q;
   logic          fin_q;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] idx_n;
   logic [DW-1:0] mem_q [N*N];

   logic rise, accept, last_acc, load, set_ovr;

   always_comb begin
      rise     = finished & ~fin_q;
      accept   = out_valid & out_ready;
      last_acc = accept & out_last;
      // A rise on the final accepted beat chains straight into the next matrix.
      load     = rise & ((state_q == StIdle) | last_acc);
      set_ovr  = rise & (state_q == StDrain) & ~last_acc;
      idx_n    = idx_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         fin_q     <= 1'b1;
         idx_q     <= '0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         for (int i = 0; i < N*N; i++) mem_q[i] <= '0;
      end else begin
         fin_q <= finished;

         if (set_ovr) overrun <= 1'b1;
         else if (clr_ovr) overrun <= 1'b0;

         if (load) begin
            for (int i = 0; i < N*N; i++) mem_q[i] <= s_flat[i*DW +: DW];
            state_q   <= StDrain;
            idx_q     <= '0;
            out_data  <= s_flat[DW-1:0];
            out_row   <= '0;
            out_col   <= '0;
            out_valid <= 1'b1;
            out_last  <= (N == 1);
            busy      <= 1'b1;
         end else if (last_acc) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
         end else if (accept) begin
            idx_q    <= idx_n;
            out_data <= mem_q[idx_n];
            out_last <= (idx_n == LastIdx);
            if (out_col == LastRc) begin
               out_col <= '0;
               out_row <= out_row + 1'b1;
            end else begin
               out_col <= out_col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain (N=4, DW=8).
// Expected beats come from a base + 16*row + col matrix pattern.
module tb_result_drain;

   localparam int N  = 4;
   localparam int DW = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              finished = 1'b0;
   logic              out_ready = 1'b0;
   logic              clr_ovr = 1'b0;
   logic [N*N*DW-1:0] s_flat = '0;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_row;
   logic [1:0]        out_col;
   logic              out_valid;
   logic              out_last;
   logic              busy;
   logic              overrun;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   result_drain #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_flat    (s_flat),
      .finished  (finished),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .overrun   (overrun),
      .clr_ovr   (clr_ovr)
   );

   function automatic logic [7:0] el(input logic [7:0] base, input int k);
      return base + 8'(16 * (k / 4) + k % 4);
   endfunction

   function automatic logic [N*N*DW-1:0] mat(input logic [7:0] base);
      logic [N*N*DW-1:0] m;
      for (int k = 0; k < N*N; k++) m[k*8 +: 8] = el(base, k);
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic beat(input string tag, input logic [7:0] base, input int k);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".data"},  32'(out_data),  32'(el(base, k)));
      check({tag, ".row"},   32'(out_row),   32'(k / 4));
      check({tag, ".col"},   32'(out_col),   32'(k % 4));
      check({tag, ".last"},  32'(out_last),  32'(k == 15));
   endtask

   task automatic idle(input string tag);
      check({tag, ".valid"}, 32'(out_valid), 32'd0);
      check({tag, ".busy"},  32'(busy),      32'd0);
      check({tag, ".last"},  32'(out_last),  32'd0);
   endtask

   // Genuine 0->1 on finished; capture happens at the following rising edge.
   task automatic fire();
      @(negedge clk) finished = 1'b0;
      @(negedge clk) finished = 1'b1;
   endtask

   initial begin
      int k;
      logic [3:0] pat;
      pat = 4'b1001;

      // Reset state
      s_flat = mat(8'h00);
      repeat (2) @(negedge clk);
      check("rst.valid", 32'(out_valid), 32'd0);
      check("rst.busy",  32'(busy),      32'd0);
      check("rst.ovr",   32'(overrun),   32'd0);
      check("rst.data",  32'(out_data),  32'd0);
      check("rst.row",   32'(out_row),   32'd0);
      check("rst.col",   32'(out_col),   32'd0);
      check("rst.last",  32'(out_last),  32'd0);
      rst = 1'b0;

      // Basic drain
      out_ready = 1'b1;
      fire();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         beat("basic", 8'h00, i);
         check("basic.busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      idle("basic.end");

      // Backpressure with ready pattern 1,0,0,1
      s_flat = mat(8'h40);
      out_ready = 1'b0;
      fire();
      k = 0;
      for (int cyc = 0; cyc < 100 && k < 16; cyc++) begin
         @(negedge clk);
         beat("bp", 8'h40, k);
         out_ready = pat[cyc % 4];
         if (out_ready) k++;
      end
      check("bp.count", 32'(k), 32'd16);
      @(negedge clk);
      idle("bp.end");
      out_ready = 1'b1;

      // Overrun: second rise at beat 5 is dropped
      s_flat = mat(8'h00);
      fire();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         beat("ovr", 8'h00, i);
         check("ovr.flag", 32'(overrun), 32'(i >= 6));
         if (i == 4) finished = 1'b0;
         if (i == 5) begin
            finished = 1'b1;
            s_flat = mat(8'h80);
         end
      end
      @(negedge clk);
      idle("ovr.end");
      check("ovr.sticky", 32'(overrun), 32'd1);
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
      check("ovr.clr", 32'(overrun), 32'd0);

      // Back-to-back: rise on the accepted last beat
      s_flat = mat(8'h00);
      fire();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         beat("b2b.a", 8'h00, i);
         if (i == 14) finished = 1'b0;
         if (i == 15) begin
            finished = 1'b1;
            s_flat = mat(8'h90);
         end
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         beat("b2b.b", 8'h90, i);
         if (i == 0) begin
            check("b2b.busy", 32'(busy),    32'd1);
            check("b2b.ovr",  32'(overrun), 32'd0);
         end
      end
      @(negedge clk);
      idle("b2b.end");

      // Reset mid-drain with finished held high
      s_flat = mat(8'h00);
      fire();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         beat("mrst", 8'h00, i);
      end
      rst = 1'b1;
      #1;
      check("mrst.valid", 32'(out_valid), 32'd0);
      check("mrst.data",  32'(out_data),  32'd0);
      check("mrst.row",   32'(out_row),   32'd0);
      check("mrst.col",   32'(out_col),   32'd0);
      check("mrst.last",  32'(out_last),  32'd0);
      check("mrst.busy",  32'(busy),      32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      s_flat = mat(8'h20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("mrst.quiet", 32'(out_valid), 32'd0);
      end
      fire();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         beat("mrst.new", 8'h20, i);
      end
      @(negedge clk);
      idle("mrst.end");

      // Input isolation: s_flat scrambled every cycle after capture
      s_flat = mat(8'h50);
      fire();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         beat("iso", 8'h50, i);
         s_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(negedge clk);
      idle("iso.end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
